// File: rtl/lfsr_checker_if.sv
// Bundles the data-side handshake and status signals of the LFSR checker.
// The master drives words and control; the slave (the checker) returns status.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  logic             enable;
  logic             up_down;
  logic             data_valid;
  logic [7:0]       data_in;
  logic             clear_err;
  logic             locked;
  logic             error;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       expected;

  modport master (
    output enable, up_down, data_valid, data_in, clear_err,
    input  locked, error, err_count, expected
  );

  modport slave (
    input  enable, up_down, data_valid, data_in, clear_err,
    output locked, error, err_count, expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR pattern stream.
// Hunts for a usable seed, confirms it over SYNC_COUNT correct predictions,
// then flywheels the prediction while locked, flagging and counting mismatches
// and dropping back to hunting after LOSS_COUNT consecutive misses.
module lfsr_checker #(
  parameter int SYNC_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [7:0]       expected_q, expected_n;
  logic [3:0]       match_cnt, match_n;
  logic [3:0]       miss_cnt, miss_n;
  logic             mode, mode_n;
  logic             error_q, error_n;
  logic             locked_q, locked_n;
  logic [ERR_W-1:0] err_q, err_n;

  logic       evt;
  logic       mode_change;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

  // Transmitter next-state function; 1 selects the up sequence.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic up);
    if (up)
      lfsr_next = {~^(x & 8'b0110_0011), x[7:1]};
    else
      lfsr_next = {x[6:0], ~^(x & 8'b1011_0001)};
  endfunction

  assign evt         = bus.enable & bus.data_valid;
  assign mode_change = (bus.up_down != mode);
  assign match_inc   = match_cnt + 4'd1;
  assign miss_inc    = miss_cnt + 4'd1;

  // Register all checker state; an active-low reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HUNT;
      expected_q <= 8'h00;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      mode       <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      state      <= state_n;
      expected_q <= expected_n;
      match_cnt  <= match_n;
      miss_cnt   <= miss_n;
      mode       <= mode_n;
      error_q    <= error_n;
      locked_q   <= locked_n;
      err_q      <= err_n;
    end
  end

  // Next-state, prediction and error-count logic for one received word.
  always_comb begin
    logic inc;
    state_n    = state;
    expected_n = expected_q;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    mode_n     = mode;
    error_n    = 1'b0;
    inc        = 1'b0;

    if (evt) begin
      unique case (state)
        HUNT: begin
          if (bus.data_in != 8'hFF) begin
            expected_n = lfsr_next(bus.data_in, bus.up_down);
            mode_n     = bus.up_down;
            match_n    = 4'd0;
            state_n    = SYNC;
          end
        end
        SYNC: begin
          if (mode_change) begin
            state_n = HUNT;
          end else if (bus.data_in == expected_q) begin
            match_n    = match_inc;
            expected_n = lfsr_next(bus.data_in, mode);
            if (match_inc == 4'(SYNC_COUNT)) begin
              state_n = LOCKED;
              miss_n  = 4'd0;
            end
          end else if (bus.data_in == 8'hFF) begin
            match_n = 4'd0;
            state_n = HUNT;
          end else begin
            expected_n = lfsr_next(bus.data_in, mode);
            match_n    = 4'd0;
          end
        end
        LOCKED: begin
          if (mode_change) begin
            state_n = HUNT;
          end else begin
            expected_n = lfsr_next(expected_q, mode);
            if (bus.data_in == expected_q) begin
              miss_n = 4'd0;
            end else begin
              error_n = 1'b1;
              inc     = 1'b1;
              miss_n  = miss_inc;
              if (miss_inc == 4'(LOSS_COUNT))
                state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end

    locked_n = (state_n == LOCKED);

    if (inc)
      err_n = bus.clear_err ? ERR_W'(1) : ((&err_q) ? err_q : err_q + ERR_W'(1));
    else if (bus.clear_err)
      err_n = '0;
    else
      err_n = err_q;
  end

  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
  assign bus.err_count = err_q;
  assign bus.expected  = expected_q;

endmodule
